nmr_bstrm_loop_cnt: RTL and testbench
=====================================

# nmr_bstrm_loop_cnt

Multi-channel NMR pulse-sequence bitstream generator. Fetches command words from on-chip SRAM, drives an N_CH-bit output word for a programmed dwell count, and executes nested hardware loops via an internal loop stack. Successor to the single-output bitstream counter. Sits between the HPS-written sequence RAM and the TX/RX gating lines of the NMR front end.

## Interface

Parameters:
- N_CH, 5: output channel count (width of OUT).
- CNT_WIDTH, 24: dwell/iteration count field width.
- LOOP_DEPTH, 4: maximum loop nesting.
- SRAM_ADDR_WIDTH, 8: sequence RAM address width.
- SRAM_DAT_WIDTH, 32: sequence RAM data width; must be ≥ 3+N_CH+CNT_WIDTH.
- IDLE_VAL, 0: OUT value when idle, done or aborted.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle start strobe; ignored while BUSY.
- ABORT  in  1  synchronous abort, any state.
- OUT  out  N_CH  channel output word.
- BUSY  out  1  high from first FETCH through final dwell.
- DONE  out  1  one-cycle pulse on normal completion.
- ERR  out  1  sticky loop-stack fault; cleared by next accepted START.
- SRAM_ADDR  out  SRAM_ADDR_WIDTH  command address.
- SRAM_CS  out  1  read strobe; data valid one cycle later.
- SRAM_RD_DAT  in  SRAM_DAT_WIDTH  read data.

## Operation

- Word format, MSB first: SEQ_END, LOOP_STA, LOOP_STO, [unused], CHAN[N_CH-1:0], COUNT[CNT_WIDTH-1:0] (CHAN/COUNT packed in the low bits).
- States: IDLE, FETCH, LATCH, RUN, FIN.
- IDLE: START → addr=0, ERR=0, FETCH.
- FETCH: SRAM_CS=1, SRAM_ADDR=addr → LATCH.
- LATCH: SRAM_CS=0, decode SRAM_RD_DAT; priority LOOP_STA > LOOP_STO > emit.
  - LOOP_STA: push {addr+1, max(COUNT,1)}; addr++ → FETCH. Push when full → ERR, abort sequence.
  - LOOP_STO: empty stack → ERR, abort. Top remaining > 1: decrement, addr = top return address → FETCH. Else pop, addr++ → FETCH.
  - Emit: OUT ← CHAN. SEQ_END=0: run counter = max(COUNT,3)−2, addr++ → RUN. SEQ_END=1: counter = max(COUNT,3) → RUN, then FIN.
- RUN: decrement; at 1 → FETCH (or FIN if final word).
- FIN: OUT=IDLE_VAL, DONE=1, BUSY=0 → IDLE.
- Abort (ABORT or stack fault): next edge OUT=IDLE_VAL, SRAM_CS=0, stack cleared, BUSY=0, no DONE, → IDLE.
- Address increment wraps 2^SRAM_ADDR_WIDTH−1 → 0 without error.

## Timing

- Reset: OUT=IDLE_VAL, BUSY=0, DONE=0, ERR=0, SRAM_CS=0, SRAM_ADDR=0, state IDLE, stack empty.
- START sampled at edge k → SRAM_CS high cycle k+1, data captured at edge k+2, OUT updates at edge k+2.
- Every emitted word holds OUT for exactly max(COUNT,3) cycles, including next word's FETCH/LATCH.
- Each control word (LOOP_STA/LOOP_STO) adds 2 cycles to the preceding emitted dwell.
- ABORT has priority over START and all decode actions in the same cycle.
- START while BUSY: ignored, no effect on ERR.
- Registered outputs only; no combinational path from inputs to outputs.

## Structure

- Package nmr_bstrm_pkg: flag bit positions, state enum, minimum-dwell constant (3), control-word overhead (2).
- Sub-module nmr_loop_stack: LOOP_DEPTH × {addr, iteration count} LIFO with push, pop, decrement-top, full, empty, clear.
- Top holds FSM, address register, dwell counter, output register.

## Test plan

- Single emit: word0 = SEQ_END, CHAN=5'h15, COUNT=20 → OUT=5'h15 for 20 cycles starting edge k+2, then IDLE_VAL, DONE pulse 1 cycle.
- Short dwell: COUNT=0 and COUNT=1 → 3-cycle dwell each; COUNT=3 → 3 cycles.
- Loop: STA COUNT=4; emit CHAN=1 COUNT=10; emit CHAN=2 COUNT=10; STO; emit END CHAN=0 COUNT=5 → pattern 1,2 repeats 4×, CHAN=2 dwell 12 each iteration (STO overhead), 4 fetches of address 1.
- Nesting: depth-LOOP_DEPTH nest with counts 2 → innermost body emitted 2^4=16 times; fifth nested STA → ERR=1, OUT=IDLE_VAL, no DONE.
- Fault: LOOP_STO as word0 → ERR=1 within 2 cycles of START, BUSY drops, ERR clears on next START.
- Abort/reset: ABORT mid-RUN → OUT=IDLE_VAL next edge, SRAM_CS=0, no DONE; RST low mid-RUN → all outputs at reset values immediately.

Source files
------------

// File: rtl/nmr_bstrm_pkg.sv
//------------------------------------------------------------------------------
// nmr_bstrm_pkg : shared constants and state encoding for the NMR bitstream
//                 loop counter. Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

package nmr_bstrm_pkg;

  // Flag positions, counted down from the command word MSB
  localparam int C_SEQ_END_OFS  = 0;
  localparam int C_LOOP_STA_OFS = 1;
  localparam int C_LOOP_STO_OFS = 2;
  localparam int C_FLAG_BITS    = 3;

  localparam int C_MIN_DWELL     = 3;
  localparam int C_CTRL_OVERHEAD = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_RUN   = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/nmr_loop_stack.sv
//------------------------------------------------------------------------------
// nmr_loop_stack : LIFO of {return address, remaining iterations} for nested
//                  hardware loops. Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module nmr_loop_stack #(
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int CW    = 24
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          dec_i,
  input  logic [AW-1:0] push_addr_i,
  input  logic [CW-1:0] push_cnt_i,
  output logic [AW-1:0] top_addr_o,
  output logic [CW-1:0] top_cnt_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int C_PW = $clog2(DEPTH + 1);
  localparam int C_IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]   addr_q [DEPTH];
  logic [CW-1:0]   cnt_q  [DEPTH];
  logic [C_PW-1:0] ptr_q;

  logic [C_PW-1:0] w_top_ptr;
  logic [C_IW-1:0] w_top_idx;
  logic [C_IW-1:0] w_wr_idx;

  assign w_top_ptr  = ptr_q - C_PW'(1);
  assign w_top_idx  = w_top_ptr[C_IW-1:0];
  assign w_wr_idx   = ptr_q[C_IW-1:0];
  assign empty_o    = (ptr_q == '0);
  assign full_o     = (ptr_q == C_PW'(DEPTH));
  assign top_addr_o = empty_o ? '0 : addr_q[w_top_idx];
  assign top_cnt_o  = empty_o ? '0 : cnt_q[w_top_idx];

  // Callers guarantee push only when not full and pop/dec only when not empty
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else if (clear_i) begin
      ptr_q <= '0;
    end else if (push_i) begin
      addr_q[w_wr_idx] <= push_addr_i;
      cnt_q[w_wr_idx]  <= push_cnt_i;
      ptr_q            <= ptr_q + C_PW'(1);
    end else if (pop_i) begin
      ptr_q <= w_top_ptr;
    end else if (dec_i) begin
      cnt_q[w_top_idx] <= cnt_q[w_top_idx] - CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/nmr_bstrm_loop_cnt.sv
//------------------------------------------------------------------------------
// nmr_bstrm_loop_cnt : multi-channel NMR pulse-sequence bitstream generator
//                      with nested hardware loops. Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module nmr_bstrm_loop_cnt
  import nmr_bstrm_pkg::*;
#(
  parameter int              N_CH            = 5,
  parameter int              CNT_WIDTH       = 24,
  parameter int              LOOP_DEPTH      = 4,
  parameter int              SRAM_ADDR_WIDTH = 8,
  parameter int              SRAM_DAT_WIDTH  = 32,
  parameter logic [N_CH-1:0] IDLE_VAL        = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic                       abort_i,
  output logic [N_CH-1:0]            out_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr_o,
  output logic                       sram_cs_o,
  input  logic [SRAM_DAT_WIDTH-1:0]  sram_rd_dat_i
);

  localparam int C_BIT_END = SRAM_DAT_WIDTH - 1 - C_SEQ_END_OFS;
  localparam int C_BIT_STA = SRAM_DAT_WIDTH - 1 - C_LOOP_STA_OFS;
  localparam int C_BIT_STO = SRAM_DAT_WIDTH - 1 - C_LOOP_STO_OFS;
  localparam logic [CNT_WIDTH-1:0] C_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] C_MIN   = CNT_WIDTH'(C_MIN_DWELL);
  localparam logic [CNT_WIDTH-1:0] C_OVHD  = CNT_WIDTH'(C_CTRL_OVERHEAD);

  state_e                     state_q;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]       cnt_q;
  logic [N_CH-1:0]            out_q;
  logic                       busy_q, done_q, err_q, cs_q, last_q;

  logic                       w_is_end, w_is_sta, w_is_sto;
  logic [N_CH-1:0]            w_chan;
  logic [CNT_WIDTH-1:0]       w_count, w_dwell, w_iter, w_top_cnt;
  logic [SRAM_ADDR_WIDTH-1:0] w_addr_inc, w_top_addr;
  logic                       w_latch, w_fault, w_full, w_empty, w_repeat;
  logic                       w_push, w_pop, w_dec, w_clear;

  assign w_is_end   = sram_rd_dat_i[C_BIT_END];
  assign w_is_sta   = sram_rd_dat_i[C_BIT_STA];
  assign w_is_sto   = sram_rd_dat_i[C_BIT_STO];
  assign w_chan     = sram_rd_dat_i[CNT_WIDTH +: N_CH];
  assign w_count    = sram_rd_dat_i[CNT_WIDTH-1:0];
  assign w_dwell    = (w_count < C_MIN) ? C_MIN : w_count;
  assign w_iter     = (w_count == '0) ? C_ONE : w_count;
  assign w_addr_inc = addr_q + SRAM_ADDR_WIDTH'(1);

  // Stack actions only happen on a non-aborted decode; abort wins everything
  assign w_latch  = (state_q == ST_LATCH) && !abort_i;
  assign w_fault  = w_latch && (w_is_sta ? w_full : (w_is_sto && w_empty));
  assign w_repeat = (w_top_cnt > C_ONE);
  assign w_push   = w_latch && w_is_sta && !w_full;
  assign w_dec    = w_latch && !w_is_sta && w_is_sto && !w_empty && w_repeat;
  assign w_pop    = w_latch && !w_is_sta && w_is_sto && !w_empty && !w_repeat;
  assign w_clear  = abort_i || w_fault;

  nmr_loop_stack #(
    .DEPTH (LOOP_DEPTH),
    .AW    (SRAM_ADDR_WIDTH),
    .CW    (CNT_WIDTH)
  ) u_stack (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (w_clear),
    .push_i      (w_push),
    .pop_i       (w_pop),
    .dec_i       (w_dec),
    .push_addr_i (w_addr_inc),
    .push_cnt_i  (w_iter),
    .top_addr_o  (w_top_addr),
    .top_cnt_o   (w_top_cnt),
    .full_o      (w_full),
    .empty_o     (w_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      out_q   <= IDLE_VAL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cs_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        state_q <= ST_IDLE;
        out_q   <= IDLE_VAL;
        cs_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              addr_q  <= '0;
              err_q   <= 1'b0;
              cs_q    <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            cs_q    <= 1'b0;
            state_q <= ST_LATCH;
          end
          ST_LATCH: begin
            if (w_fault) begin
              err_q   <= 1'b1;
              out_q   <= IDLE_VAL;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else if (w_is_sta || w_is_sto) begin
              addr_q  <= (w_is_sto && !w_is_sta && w_repeat) ? w_top_addr : w_addr_inc;
              cs_q    <= 1'b1;
              state_q <= ST_FETCH;
            end else begin
              // Non-final dwell is shortened by the next word's fetch/latch
              out_q   <= w_chan;
              last_q  <= w_is_end;
              cnt_q   <= w_is_end ? w_dwell : (w_dwell - C_OVHD);
              if (!w_is_end) addr_q <= w_addr_inc;
              state_q <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (cnt_q == C_ONE) begin
              if (last_q) begin
                out_q   <= IDLE_VAL;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= ST_FIN;
              end else begin
                cs_q    <= 1'b1;
                state_q <= ST_FETCH;
              end
            end else begin
              cnt_q <= cnt_q - C_ONE;
            end
          end
          ST_FIN: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign out_o       = out_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign sram_addr_o = addr_q;
  assign sram_cs_o   = cs_q;

endmodule

`default_nettype wire

// File: tb/tb_nmr_bstrm_loop_cnt.sv
//------------------------------------------------------------------------------
// tb_nmr_bstrm_loop_cnt : directed scoreboard bench; expected OUT dwell
//                         segments are queued per program. Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_nmr_bstrm_loop_cnt;

  localparam int N_CH = 5;
  localparam int CW   = 24;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam logic [N_CH-1:0] IDLE = '0;

  typedef struct packed {
    logic [N_CH-1:0] chan;
    logic [31:0]     len;
  } seg_t;

  logic            clk = 1'b0;
  logic            rst_n, start, abort;
  logic [N_CH-1:0] out;
  logic            busy, done, err, sram_cs;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   rd_dat;
  logic [DW-1:0]   mem [256];
  int              fetch1_cnt = 0;
  int              vecs = 0;
  int              errs = 0;
  seg_t            exp_q [$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_cs) rd_dat <= mem[sram_addr];
    if (sram_cs && sram_addr == 8'd1) fetch1_cnt <= fetch1_cnt + 1;
  end

  nmr_bstrm_loop_cnt #(
    .N_CH(N_CH), .CNT_WIDTH(CW), .LOOP_DEPTH(4),
    .SRAM_ADDR_WIDTH(AW), .SRAM_DAT_WIDTH(DW), .IDLE_VAL(IDLE)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .out_o(out), .busy_o(busy), .done_o(done), .err_o(err),
    .sram_addr_o(sram_addr), .sram_cs_o(sram_cs), .sram_rd_dat_i(rd_dat)
  );

  function automatic logic [DW-1:0] mkw(input bit e, input bit sta, input bit sto,
                                        input logic [N_CH-1:0] ch, input logic [CW-1:0] c);
    return {e, sta, sto, ch, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [N_CH-1:0] ch, input int len);
    seg_t e;
    e.chan = ch;
    e.len  = len;
    exp_q.push_back(e);
  endtask

  task automatic close_seg(input logic [N_CH-1:0] ch, input int len);
    seg_t e;
    chk("seg_avail", 32'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("seg_chan", 32'(ch), 32'(e.chan));
      chk("seg_len", len, e.len);
    end
  endtask

  // Pulse START, then split OUT into constant-value segments until DONE/ERR
  task automatic run_seq(input int max_cyc, input bit restrobe,
                         output bit saw_done, output bit saw_err,
                         output int first_s, output int end_s);
    logic [N_CH-1:0] cur;
    int len, s;
    bit active;
    saw_done = 0; saw_err = 0; first_s = -1; end_s = -1;
    active = 0; len = 0; cur = IDLE;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    s = 1;
    chk("start_cs", 32'(sram_cs), 1);
    chk("start_addr", 32'(sram_addr), 0);
    chk("start_busy", 32'(busy), 1);
    chk("start_err", 32'(err), 0);
    while (!saw_done && !saw_err && s <= max_cyc) begin
      if (done || err) begin
        if (active) close_seg(cur, len);
        saw_done = done; saw_err = err; end_s = s;
      end else if (!active) begin
        if (out != IDLE) begin
          active = 1; cur = out; len = 1; first_s = s;
        end
      end else if (out != cur) begin
        close_seg(cur, len);
        cur = out; len = 1;
      end else begin
        len++;
      end
      if (!saw_done && !saw_err) begin
        if (restrobe) start = (s == 5);
        @(negedge clk);
        s++;
      end
    end
    chk("run_timeout", 32'(saw_done || saw_err), 1);
    chk("seg_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    bit sd, se;
    int fs, es, f0, t, sn, ndone;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out", 32'(out), 32'(IDLE));
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cs", 32'(sram_cs), 0);
    chk("rst_addr", 32'(sram_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single final word
    mem[0] = mkw(1, 0, 0, 5'h15, 24'd20);
    push_exp(5'h15, 20);
    run_seq(200, 0, sd, se, fs, es);
    chk("single_first", fs, 3);
    chk("single_end", es, 23);
    chk("single_done", 32'(sd), 1);
    chk("single_err", 32'(se), 0);
    @(negedge clk);
    chk("single_done_1cyc", 32'(done), 0);
    chk("single_idle_out", 32'(out), 32'(IDLE));
    chk("single_busy_low", 32'(busy), 0);

    // Short dwells, with a START while busy that must be ignored
    mem[0] = mkw(0, 0, 0, 5'd1, 24'd0);
    mem[1] = mkw(0, 0, 0, 5'd2, 24'd1);
    mem[2] = mkw(0, 0, 0, 5'd3, 24'd3);
    mem[3] = mkw(1, 0, 0, 5'd4, 24'd0);
    push_exp(5'd1, 3); push_exp(5'd2, 3); push_exp(5'd3, 3); push_exp(5'd4, 3);
    run_seq(200, 1, sd, se, fs, es);
    chk("short_done", 32'(sd), 1);

    // Single loop of 4 iterations
    mem[0] = mkw(0, 1, 0, 5'd0, 24'd4);
    mem[1] = mkw(0, 0, 0, 5'd1, 24'd10);
    mem[2] = mkw(0, 0, 0, 5'd2, 24'd10);
    mem[3] = mkw(0, 0, 1, 5'd0, 24'd0);
    mem[4] = mkw(1, 0, 0, 5'd0, 24'd5);
    for (int i = 0; i < 4; i++) begin
      push_exp(5'd1, 10);
      push_exp(5'd2, 12);
    end
    push_exp(5'd0, 5);
    f0 = fetch1_cnt;
    run_seq(500, 0, sd, se, fs, es);
    chk("loop_done", 32'(sd), 1);
    chk("loop_fetch1", fetch1_cnt - f0, 4);

    // Four nested loops of 2; each trailing STO and re-entered STA adds 2 cycles
    for (int i = 0; i < 4; i++) mem[i] = mkw(0, 1, 0, 5'd0, 24'd2);
    mem[4] = mkw(0, 0, 0, 5'd3, 24'd5);
    mem[5] = mkw(0, 0, 0, 5'd4, 24'd5);
    for (int i = 6; i < 10; i++) mem[i] = mkw(0, 0, 1, 5'd0, 24'd0);
    mem[10] = mkw(1, 0, 0, 5'd7, 24'd3);
    for (int n = 0; n < 16; n++) begin
      push_exp(5'd3, 5);
      t = 0;
      while (t < 4 && n[t]) t++;
      sn = (n == 15) ? 4 : t + 1;
      push_exp(5'd4, (n == 15) ? 5 + 2 * sn : 5 + 2 * sn + 2 * (sn - 1));
    end
    push_exp(5'd7, 3);
    run_seq(1500, 0, sd, se, fs, es);
    chk("nest_done", 32'(sd), 1);
    chk("nest_err", 32'(se), 0);

    // Fifth nested STA overflows the stack
    for (int i = 0; i < 5; i++) mem[i] = mkw(0, 1, 0, 5'd0, 24'd2);
    mem[5] = mkw(1, 0, 0, 5'd9, 24'd5);
    run_seq(200, 0, sd, se, fs, es);
    chk("ovf_err", 32'(se), 1);
    chk("ovf_done", 32'(sd), 0);
    chk("ovf_out", 32'(out), 32'(IDLE));
    chk("ovf_busy", 32'(busy), 0);

    // STO with an empty stack
    mem[0] = mkw(0, 0, 1, 5'd0, 24'd0);
    run_seq(50, 0, sd, se, fs, es);
    chk("sto_err", 32'(se), 1);
    chk("sto_err_time", es, 3);
    chk("sto_busy", 32'(busy), 0);
    repeat (4) @(negedge clk);
    chk("sto_err_sticky", 32'(err), 1);

    // ERR cleared by next accepted START (checked at start of run)
    mem[0] = mkw(1, 0, 0, 5'h15, 24'd20);
    push_exp(5'h15, 20);
    run_seq(200, 0, sd, se, fs, es);
    chk("rerun_done", 32'(sd), 1);

    // Abort mid-run
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_pre_out", 32'(out), 32'h15);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_out", 32'(out), 32'(IDLE));
    chk("abort_cs", 32'(sram_cs), 0);
    chk("abort_busy", 32'(busy), 0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", ndone, 0);

    // Asynchronous reset mid-run
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_pre_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out", 32'(out), 32'(IDLE));
    chk("arst_busy", 32'(busy), 0);
    chk("arst_cs", 32'(sram_cs), 0);
    chk("arst_done", 32'(done), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_stays_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

`default_nettype wire
